// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: stage-control bundle,
// wait-state encoding and the bubble instruction.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LS_WAIT = 2'd1,
        ST_MD_WAIT = 2'd2,
        ST_IF_WAIT = 2'd3
    } state_e;

    typedef struct packed {
        logic stall_pc;
        logic stall_id;
        logic stall_ex;
        logic stall_ls;
        logic flush_id;
        logic flush_ex;
        logic flush_ls;
        logic flush_wb;
    } stage_ctrl_t;

    // addi x0, x0, 0 -- what a flushed stage register carries
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic state_e wait_cause(input logic ls_wait,
                                          input logic md_busy,
                                          input logic if_wait);
        if (ls_wait)      return ST_LS_WAIT;
        else if (md_busy) return ST_MD_WAIT;
        else if (if_wait) return ST_IF_WAIT;
        else              return ST_RUN;
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use detector: a load in EX whose rd is read by the instruction in ID.
module pipe_ctrl_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs1_idx_i,
    input  logic [4:0] rs2_idx_i,
    input  logic       rs1_used_i,
    input  logic       rs2_used_i,
    input  logic [4:0] rd_idx_i,
    input  logic       wben_i,
    input  logic       is_load_i,
    output logic       load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = rs1_used_i & (rs1_idx_i == rd_idx_i);
    assign rs2_hit    = rs2_used_i & (rs2_idx_i == rd_idx_i);
    assign load_use_o = is_load_i & wben_i & (|rd_idx_i) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush, PC redirect, fetch
// squash tracking, stall-cycle counter and wait-state hang watchdog.
//
//   state      | meaning
//   -----------+---------------------------------------------
//   ST_RUN     | no wait cause active
//   ST_LS_WAIT | data-memory access outstanding
//   ST_MD_WAIT | mul/div in EX not finished
//   ST_IF_WAIT | instruction fetch outstanding
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_idx_id_i,
    input  logic [4:0]       rs2_idx_id_i,
    input  logic             rs1_used_id_i,
    input  logic             rs2_used_id_i,
    input  logic [4:0]       rd_idx_ex_i,
    input  logic             wben_ex_i,
    input  logic             is_load_ex_i,
    input  logic             is_jump_ex_i,
    input  logic [XLEN-1:0]  pc_jump_ex_i,
    input  logic             md_busy_ex_i,
    input  logic             if_req_i,
    input  logic             if_ready_i,
    input  logic             ls_req_i,
    input  logic             ls_ready_i,
    output logic             stall_pc_o,
    output logic             stall_id_o,
    output logic             stall_ex_o,
    output logic             stall_ls_o,
    output logic             flush_id_o,
    output logic             flush_ex_o,
    output logic             flush_ls_o,
    output logic             flush_wb_o,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             if_squash_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             hang_o
);

    localparam int              WC_W   = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              squash_q, squash_d;
    logic              hang_q, hang_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    stage_ctrl_t       ctrl;
    logic              redirect;
    logic              squash_hit;
    logic              load_use;
    logic              ls_wait;
    logic              if_wait;
    state_e            cause;

    pipe_ctrl_hazard_detect u_hazard_detect (
        .rs1_idx_i  (rs1_idx_id_i),
        .rs2_idx_i  (rs2_idx_id_i),
        .rs1_used_i (rs1_used_id_i),
        .rs2_used_i (rs2_used_id_i),
        .rd_idx_i   (rd_idx_ex_i),
        .wben_i     (wben_ex_i),
        .is_load_i  (is_load_ex_i),
        .load_use_o (load_use)
    );

    assign ls_wait = ls_req_i & ~ls_ready_i;
    assign if_wait = if_req_i & ~if_ready_i;
    assign cause   = wait_cause(ls_wait, md_busy_ex_i, if_wait);

    // Only the highest-priority cause shapes the controls.
    always_comb begin
        ctrl       = '0;
        redirect   = 1'b0;
        squash_hit = 1'b0;
        if (ls_wait) begin
            ctrl.stall_pc = 1'b1;
            ctrl.stall_id = 1'b1;
            ctrl.stall_ex = 1'b1;
            ctrl.stall_ls = 1'b1;
            ctrl.flush_wb = 1'b1;
        end else if (md_busy_ex_i) begin
            ctrl.stall_pc = 1'b1;
            ctrl.stall_id = 1'b1;
            ctrl.stall_ex = 1'b1;
            ctrl.flush_ls = 1'b1;
        end else if (is_jump_ex_i) begin
            redirect      = 1'b1;
            ctrl.flush_id = 1'b1;
            ctrl.flush_ex = 1'b1;
        end else if (load_use) begin
            ctrl.stall_pc = 1'b1;
            ctrl.stall_id = 1'b1;
            ctrl.flush_ex = 1'b1;
        end else if (if_wait) begin
            ctrl.stall_pc = 1'b1;
            ctrl.flush_id = 1'b1;
        end
        // A response that belongs to the pre-redirect path is dropped.
        squash_hit = if_ready_i & (squash_q | redirect);
        if (squash_hit) begin
            ctrl.flush_id = 1'b1;
        end
        if (rst) begin
            ctrl       = '0;
            redirect   = 1'b0;
            squash_hit = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        squash_d    = squash_q;
        hang_d      = hang_q;
        stall_cnt_d = stall_cnt_q + CNT_W'(ctrl.stall_pc);
        if (rst) begin
            state_d     = ST_RUN;
            wait_cnt_d  = '0;
            squash_d    = 1'b0;
            hang_d      = 1'b0;
            stall_cnt_d = '0;
        end else begin
            state_d = cause;
            if (cause == ST_RUN) begin
                wait_cnt_d = '0;
            end else if (cause != state_q) begin
                wait_cnt_d = WC_W'(1);
            end else if (wait_cnt_q != WC_MAX) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
            hang_d = hang_q | (wait_cnt_d == WC_MAX);
            if (redirect & if_wait) begin
                squash_d = 1'b1;
            end else if (squash_q & if_ready_i) begin
                squash_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        wait_cnt_q  <= wait_cnt_d;
        squash_q    <= squash_d;
        hang_q      <= hang_d;
        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_pc_o    = ctrl.stall_pc;
    assign stall_id_o    = ctrl.stall_id;
    assign stall_ex_o    = ctrl.stall_ex;
    assign stall_ls_o    = ctrl.stall_ls;
    assign flush_id_o    = ctrl.flush_id;
    assign flush_ex_o    = ctrl.flush_ex;
    assign flush_ls_o    = ctrl.flush_ls;
    assign flush_wb_o    = ctrl.flush_wb;
    assign redirect_o    = redirect;
    assign redirect_pc_o = redirect ? pc_jump_ex_i : '0;
    assign if_squash_o   = squash_hit;
    assign stall_cnt_o   = stall_cnt_q;
    assign hang_o        = hang_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, hand sequences for the
// multi-cycle corners, then random stimulus against a reference model.
module tb_pipe_ctrl;

    localparam int XLEN    = 64;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 32;
    localparam logic [63:0] TGT = 64'h0000_0000_8000_0100;

    typedef struct packed {
        logic        ls_req;
        logic        ls_ready;
        logic        md;
        logic        jump;
        logic [63:0] pc;
        logic        load;
        logic        wben;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        if_req;
        logic        if_ready;
    } inp_t;

    // stall bits {ls,ex,id,pc}; flush bits {wb,ls,ex,id}
    typedef struct packed {
        inp_t       in;
        logic [3:0] st;
        logic [3:0] fl;
        logic       rd;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       rs1_idx, rs2_idx, rd_idx;
    logic             rs1_used, rs2_used, wben, is_load, is_jump, md_busy;
    logic [XLEN-1:0]  pc_jump;
    logic             if_req, if_ready, ls_req, ls_ready;
    logic             stall_pc, stall_id, stall_ex, stall_ls;
    logic             flush_id, flush_ex, flush_ls, flush_wb;
    logic             redirect, if_squash, hang;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_idx_id_i(rs1_idx), .rs2_idx_id_i(rs2_idx),
        .rs1_used_id_i(rs1_used), .rs2_used_id_i(rs2_used),
        .rd_idx_ex_i(rd_idx), .wben_ex_i(wben), .is_load_ex_i(is_load),
        .is_jump_ex_i(is_jump), .pc_jump_ex_i(pc_jump), .md_busy_ex_i(md_busy),
        .if_req_i(if_req), .if_ready_i(if_ready),
        .ls_req_i(ls_req), .ls_ready_i(ls_ready),
        .stall_pc_o(stall_pc), .stall_id_o(stall_id),
        .stall_ex_o(stall_ex), .stall_ls_o(stall_ls),
        .flush_id_o(flush_id), .flush_ex_o(flush_ex),
        .flush_ls_o(flush_ls), .flush_wb_o(flush_wb),
        .redirect_o(redirect), .redirect_pc_o(redirect_pc),
        .if_squash_o(if_squash), .stall_cnt_o(stall_cnt), .hang_o(hang)
    );

    function automatic inp_t mk(input logic lsq, input logic lsr, input logic md,
                                input logic jmp, input logic ld, input logic wb,
                                input logic [4:0] rd, input logic [4:0] r1,
                                input logic [4:0] r2, input logic u1, input logic u2,
                                input logic ifq, input logic ifr);
        inp_t v;
        v.ls_req = lsq; v.ls_ready = lsr; v.md = md; v.jump = jmp; v.pc = TGT;
        v.load = ld; v.wben = wb; v.rd = rd; v.rs1 = r1; v.rs2 = r2;
        v.u1 = u1; v.u2 = u2; v.if_req = ifq; v.if_ready = ifr;
        return v;
    endfunction

    task automatic drive(input inp_t v);
        ls_req = v.ls_req; ls_ready = v.ls_ready; md_busy = v.md;
        is_jump = v.jump; pc_jump = v.pc; is_load = v.load; wben = v.wben;
        rd_idx = v.rd; rs1_idx = v.rs1; rs2_idx = v.rs2;
        rs1_used = v.u1; rs2_used = v.u2; if_req = v.if_req; if_ready = v.if_ready;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] act_st();
        return {stall_ls, stall_ex, stall_id, stall_pc};
    endfunction

    function automatic logic [3:0] act_fl();
        return {flush_wb, flush_ls, flush_ex, flush_id};
    endfunction

    // Drive at the falling edge, sample 1 time unit later.
    task automatic step(input inp_t v);
        @(negedge clk);
        drive(v);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive('0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model: the winning cause holds a prefix of the pipe
    // (PC, ID, EX, LS) and drops a bubble into the first stage behind it.
    int m_cause, m_run;
    bit m_sq, m_hang;
    logic [CNT_W-1:0] m_cnt;

    task automatic model_eval(input inp_t v, input bit in_rst,
                              output logic [3:0] st, output logic [3:0] fl,
                              output bit rdir, output bit sq);
        bit lsw, ifw, lu;
        int hold;
        lsw  = v.ls_req && !v.ls_ready;
        ifw  = v.if_req && !v.if_ready;
        lu   = v.load && v.wben && (v.rd != 0) &&
               ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
        hold = -1;
        rdir = 0;
        if (lsw)         hold = 4;
        else if (v.md)   hold = 3;
        else if (v.jump) rdir = 1;
        else if (lu)     hold = 2;
        else if (ifw)    hold = 1;
        st = '0;
        fl = '0;
        for (int i = 0; i < 4; i++) if (i < hold) st[i] = 1'b1;
        if (hold > 0) fl[hold-1] = 1'b1;
        if (rdir) fl[1:0] = 2'b11;
        sq = v.if_ready && (m_sq || rdir);
        if (sq) fl[0] = 1'b1;
        if (in_rst) begin
            st = '0; fl = '0; rdir = 0; sq = 0;
        end
    endtask

    task automatic model_update(input inp_t v, input bit in_rst,
                                input logic [3:0] st, input bit rdir);
        int c;
        bit ifw;
        if (in_rst) begin
            m_cause = 0; m_run = 0; m_sq = 0; m_hang = 0; m_cnt = '0;
        end else begin
            ifw = v.if_req && !v.if_ready;
            if (rdir && ifw)                m_sq = 1;
            else if (m_sq && v.if_ready)    m_sq = 0;
            c = (v.ls_req && !v.ls_ready) ? 1 : v.md ? 2 : ifw ? 3 : 0;
            if (c == 0)            m_run = 0;
            else if (c == m_cause) m_run++;
            else                   m_run = 1;
            m_cause = c;
            if (m_run >= TIMEOUT) m_hang = 1;
            m_cnt += CNT_W'(st[0]);
        end
    endtask

    vec_t tbl[16];
    inp_t idle, lu5, lsw_jmp;

    initial begin
        drive('0);
        idle = '0;
        lu5  = mk(0,0,0,0, 1,1, 5'd5, 5'd5, 5'd0, 1,0, 0,0);

        tbl[0]  = '{mk(0,0,0,0, 0,0, 0,0,0, 0,0, 0,0),       4'b0000, 4'b0000, 1'b0};
        tbl[1]  = '{mk(1,0,0,0, 0,0, 0,0,0, 0,0, 0,0),       4'b1111, 4'b1000, 1'b0};
        tbl[2]  = '{mk(1,1,0,0, 0,0, 0,0,0, 0,0, 0,0),       4'b0000, 4'b0000, 1'b0};
        tbl[3]  = '{mk(0,0,1,0, 0,0, 0,0,0, 0,0, 0,0),       4'b0111, 4'b0100, 1'b0};
        tbl[4]  = '{mk(0,0,0,1, 0,0, 0,0,0, 0,0, 0,0),       4'b0000, 4'b0011, 1'b1};
        tbl[5]  = '{mk(0,0,0,0, 1,1, 5,5,9, 1,1, 0,0),       4'b0011, 4'b0010, 1'b0};
        tbl[6]  = '{mk(0,0,0,0, 1,1, 7,3,7, 0,1, 0,0),       4'b0011, 4'b0010, 1'b0};
        tbl[7]  = '{mk(0,0,0,0, 1,1, 0,0,0, 1,1, 0,0),       4'b0000, 4'b0000, 1'b0};
        tbl[8]  = '{mk(0,0,0,0, 1,1, 5,5,5, 0,0, 0,0),       4'b0000, 4'b0000, 1'b0};
        tbl[9]  = '{mk(0,0,0,0, 1,0, 5,5,0, 1,0, 0,0),       4'b0000, 4'b0000, 1'b0};
        tbl[10] = '{mk(0,0,0,0, 0,1, 5,5,0, 1,0, 0,0),       4'b0000, 4'b0000, 1'b0};
        tbl[11] = '{mk(0,0,0,0, 0,0, 0,0,0, 0,0, 1,0),       4'b0001, 4'b0001, 1'b0};
        tbl[12] = '{mk(1,0,1,1, 1,1, 5,5,0, 1,0, 1,0),       4'b1111, 4'b1000, 1'b0};
        tbl[13] = '{mk(0,0,1,1, 0,0, 0,0,0, 0,0, 0,0),       4'b0111, 4'b0100, 1'b0};
        tbl[14] = '{mk(0,0,0,1, 1,1, 5,5,0, 1,0, 0,0),       4'b0000, 4'b0011, 1'b1};
        tbl[15] = '{mk(0,0,0,0, 1,1, 31,0,31, 0,1, 1,0),     4'b0011, 4'b0010, 1'b0};

        // Reset state
        do_reset();
        #1;
        chk("reset_stall", 64'(act_st()), 64'd0);
        chk("reset_flush", 64'(act_fl()), 64'd0);
        chk("reset_redirect", 64'(redirect), 64'd0);
        chk("reset_squash", 64'(if_squash), 64'd0);
        chk("reset_cnt", 64'(stall_cnt), 64'd0);
        chk("reset_hang", 64'(hang), 64'd0);

        // Vector table, each from a fresh reset
        for (int i = 0; i < 16; i++) begin
            do_reset();
            step(tbl[i].in);
            chk($sformatf("tbl%0d_stall", i), 64'(act_st()), 64'(tbl[i].st));
            chk($sformatf("tbl%0d_flush", i), 64'(act_fl()), 64'(tbl[i].fl));
            chk($sformatf("tbl%0d_redirect", i), 64'(redirect), 64'(tbl[i].rd));
            chk($sformatf("tbl%0d_rpc", i), redirect_pc, tbl[i].rd ? TGT : 64'd0);
        end

        // Load-use: one stall cycle, then clear
        do_reset();
        step(lu5);
        chk("lu_stall", 64'(act_st()), 64'b0011);
        chk("lu_flush", 64'(act_fl()), 64'b0010);
        step(idle);
        chk("lu_after_stall", 64'(act_st()), 64'd0);
        chk("lu_after_flush", 64'(act_fl()), 64'd0);
        chk("lu_cnt", 64'(stall_cnt), 64'd1);

        // Jump held behind an LS wait redirects once
        do_reset();
        lsw_jmp = mk(1,0,0,1, 0,0, 0,0,0, 0,0, 0,0);
        for (int i = 0; i < 3; i++) begin
            step(lsw_jmp);
            chk($sformatf("jls_hold%0d_redirect", i), 64'(redirect), 64'd0);
            chk($sformatf("jls_hold%0d_stall_ex", i), 64'(stall_ex), 64'd1);
        end
        step(mk(1,1,0,1, 0,0, 0,0,0, 0,0, 0,0));
        chk("jls_go_redirect", 64'(redirect), 64'd1);
        chk("jls_go_pc", redirect_pc, TGT);
        chk("jls_go_flush", 64'(act_fl()), 64'b0011);
        step(idle);
        chk("jls_once", 64'(redirect), 64'd0);

        // Squash of an outstanding fetch
        do_reset();
        step(mk(0,0,0,1, 0,0, 0,0,0, 0,0, 1,0));
        chk("sq_redirect", 64'(redirect), 64'd1);
        chk("sq_none_yet", 64'(if_squash), 64'd0);
        step(mk(0,0,0,0, 0,0, 0,0,0, 0,0, 1,0));
        chk("sq_wait_squash", 64'(if_squash), 64'd0);
        chk("sq_wait_stall", 64'(act_st()), 64'b0001);
        step(mk(0,0,0,0, 0,0, 0,0,0, 0,0, 1,1));
        chk("sq_hit", 64'(if_squash), 64'd1);
        chk("sq_hit_flush_id", 64'(flush_id), 64'd1);
        step(mk(0,0,0,0, 0,0, 0,0,0, 0,0, 1,1));
        chk("sq_cleared", 64'(if_squash), 64'd0);
        chk("sq_cleared_flush", 64'(flush_id), 64'd0);
        step(mk(0,0,0,1, 0,0, 0,0,0, 0,0, 1,1));
        chk("sq_same_cycle", 64'(if_squash), 64'd1);
        step(mk(0,0,0,0, 0,0, 0,0,0, 0,0, 1,1));
        chk("sq_same_no_flag", 64'(if_squash), 64'd0);

        // MD busy outranks a concurrent load-use
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(mk(0,0,1,0, 1,1, 5,5,0, 1,0, 0,0));
            chk($sformatf("md%0d_stall", i), 64'(act_st()), 64'b0111);
            chk($sformatf("md%0d_flush", i), 64'(act_fl()), 64'b0100);
        end
        step(lu5);
        chk("md_then_lu_stall", 64'(act_st()), 64'b0011);
        chk("md_then_lu_flush", 64'(act_fl()), 64'b0010);
        step(idle);
        chk("md_stall_cnt", 64'(stall_cnt), 64'd6);

        // Watchdog
        do_reset();
        for (int i = 1; i <= TIMEOUT; i++) begin
            step(mk(1,0,0,0, 0,0, 0,0,0, 0,0, 0,0));
            chk($sformatf("wd_cycle%0d_hang", i), 64'(hang), 64'd0);
        end
        step(mk(1,1,0,0, 0,0, 0,0,0, 0,0, 0,0));
        chk("wd_hang_set", 64'(hang), 64'd1);
        step(idle);
        chk("wd_hang_sticky", 64'(hang), 64'd1);
        do_reset();
        #1;
        chk("wd_rst_hang", 64'(hang), 64'd0);
        chk("wd_rst_cnt", 64'(stall_cnt), 64'd0);
        chk("wd_rst_stall", 64'(act_st()), 64'd0);
        chk("wd_rst_flush", 64'(act_fl()), 64'd0);
        chk("wd_rst_redirect", 64'(redirect), 64'd0);

        // Random stimulus against the model
        do_reset();
        m_cause = 0; m_run = 0; m_sq = 0; m_hang = 0; m_cnt = '0;
        for (int n = 0; n < 600; n++) begin
            inp_t v;
            bit r, rdir, sq;
            logic [3:0] st, fl;
            r = ($urandom_range(99) < 2);
            v.ls_req   = ($urandom_range(99) < 30);
            v.ls_ready = ($urandom_range(99) < 70);
            v.md       = ($urandom_range(99) < 15);
            v.jump     = ($urandom_range(99) < 20);
            v.pc       = {$urandom, $urandom};
            v.load     = ($urandom_range(99) < 40);
            v.wben     = ($urandom_range(99) < 80);
            v.rd       = 5'($urandom_range(3));
            v.rs1      = 5'($urandom_range(3));
            v.rs2      = 5'($urandom_range(3));
            v.u1       = $urandom_range(1) != 0;
            v.u2       = $urandom_range(1) != 0;
            v.if_req   = ($urandom_range(99) < 60);
            v.if_ready = ($urandom_range(99) < 60);
            if (r) v = '0;
            @(negedge clk);
            rst = r;
            drive(v);
            #1;
            model_eval(v, r, st, fl, rdir, sq);
            chk($sformatf("rnd%0d_stall", n), 64'(act_st()), 64'(st));
            chk($sformatf("rnd%0d_flush", n), 64'(act_fl()), 64'(fl));
            chk($sformatf("rnd%0d_redirect", n), 64'(redirect), 64'(rdir));
            chk($sformatf("rnd%0d_rpc", n), redirect_pc, rdir ? v.pc : 64'd0);
            chk($sformatf("rnd%0d_squash", n), 64'(if_squash), 64'(sq));
            chk($sformatf("rnd%0d_cnt", n), 64'(stall_cnt), 64'(m_cnt));
            chk($sformatf("rnd%0d_hang", n), 64'(hang), 64'(m_hang));
            model_update(v, r, st, rdir);
        end

        @(negedge clk);
        rst = 1'b0;
        drive('0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
